// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe types: cell marks, game result, move-controller states and
// the cursor wrap rule used by the move controller.
package ttt_pkg;
    localparam int unsigned N_CELLS = 9;
    localparam int unsigned CELL_W  = 4;
    localparam int unsigned MARK_W  = 2;
    localparam logic [CELL_W-1:0] CENTER_CELL = 4'd4;

    typedef enum logic [MARK_W-1:0] {EMPTY = 2'b00, X = 2'b01, O = 2'b10} cell_t;
    typedef enum logic [MARK_W-1:0] {NONE = 2'b00, X_WIN = 2'b01, O_WIN = 2'b10, DRAW = 2'b11} who_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, OVER} ctrl_state_t;
    typedef enum logic [1:0] {DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP} dir_t;

    // Move one step on the 3x3 grid, wrapping inside the current row or column.
    function automatic logic [CELL_W-1:0] cursor_step(input logic [CELL_W-1:0] cur, input dir_t dir);
        logic [CELL_W-1:0] row;
        logic [CELL_W-1:0] col;
        logic [CELL_W-1:0] nxt;
        row = cur / 4'd3;
        col = cur % 4'd3;
        nxt = cur;
        case (dir)
            DIR_RIGHT: nxt = (col == 4'd2) ? cur - 4'd2 : cur + 4'd1;
            DIR_LEFT:  nxt = (col == 4'd0) ? cur + 4'd2 : cur - 4'd1;
            DIR_DOWN:  nxt = (row == 4'd2) ? cur - 4'd6 : cur + 4'd3;
            DIR_UP:    nxt = (row == 4'd0) ? cur + 4'd6 : cur - 4'd3;
            default:   nxt = cur;
        endcase
        return nxt;
    endfunction
endpackage

// File: rtl/ttt_move_controller_if.sv
// Button, board read-back and move-strobe signals between the player-side
// controller (master) and the board/game side (slave).
interface ttt_move_if;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic       btn_confirm;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic [1:0] who;
    logic       playX;
    logic       playO;
    logic [3:0] playerX_position;
    logic [3:0] playerO_position;
    logic [3:0] cursor;
    logic       turn;
    logic       reject;
    logic       game_over;

    modport master (
        input  btn_left, btn_right, btn_up, btn_down, btn_confirm,
        input  pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who,
        output playX, playO, playerX_position, playerO_position,
        output cursor, turn, reject, game_over
    );

    modport slave (
        output btn_left, btn_right, btn_up, btn_down, btn_confirm,
        output pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who,
        input  playX, playO, playerX_position, playerO_position,
        input  cursor, turn, reject, game_over
    );
endinterface

// File: rtl/ttt_move_controller_btn_edge.sv
// Rising-edge detector for one pre-synchronised level button.
module ttt_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise_c
);
    logic btn_q;

    always_ff @(posedge clk) begin
        if (rst) btn_q <= 1'b0;
        else     btn_q <= btn;
    end

    assign rise_c = btn & ~btn_q;
endmodule

// File: rtl/ttt_move_controller.sv
// Player-side move entry: cursor buttons to playX/playO strobes, with occupancy
// check, move acknowledge via board read-back, turn alternation and game-over stop.
module ttt_move_controller
    import ttt_pkg::*;
#(
    parameter int unsigned PLAY_CYCLES  = 5,
    parameter int unsigned ACK_TIMEOUT  = 16,
    parameter bit          FIRST_PLAYER = 1'b1
) (
    input  logic clk,
    input  logic rst,
    ttt_move_if.master bus
);
    localparam int unsigned PLAY_CW = $clog2(PLAY_CYCLES + 1);
    localparam int unsigned ACK_CW  = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned N_BTN   = 5;

    ctrl_state_t state_q, state_d;
    logic [CELL_W-1:0]  cursor_q, cursor_d, pos_x_q, pos_x_d, pos_o_q, pos_o_d;
    logic               turn_q, turn_d, play_x_q, play_x_d, play_o_q, play_o_d;
    logic               reject_q, reject_d, game_over_q, game_over_d;
    logic [PLAY_CW-1:0] issue_cnt_q;
    logic [ACK_CW-1:0]  ack_cnt_q;

    logic [N_BTN-1:0]   btn_raw, btn_rise_c;
    logic [N_CELLS-1:0][MARK_W-1:0] cells;
    logic               game_end_c, cell_free_c, acked_c;
    logic [CELL_W-1:0]  target_c;
    cell_t              mark_c;

    // Bit order: right, left, down, up, confirm.
    assign btn_raw = {bus.btn_confirm, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};

    for (genvar i = 0; i < N_BTN; i++) begin : g_edge
        ttt_btn_edge u_edge (.clk(clk), .rst(rst), .btn(btn_raw[i]), .rise_c(btn_rise_c[i]));
    end

    assign cells = {bus.pos9, bus.pos8, bus.pos7, bus.pos6, bus.pos5,
                    bus.pos4, bus.pos3, bus.pos2, bus.pos1};

    assign game_end_c  = (who_t'(bus.who) != NONE);
    assign cell_free_c = (cell_t'(cells[cursor_q]) == EMPTY);
    assign target_c    = turn_q ? pos_o_q : pos_x_q;
    assign mark_c      = turn_q ? O : X;
    assign acked_c     = (cell_t'(cells[target_c]) == mark_c);

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        turn_d   = turn_q;
        pos_x_d  = pos_x_q;
        pos_o_d  = pos_o_q;
        reject_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (game_end_c) begin
                    state_d = OVER;
                end else if (btn_rise_c[4]) begin
                    if (cell_free_c) begin
                        state_d = ISSUE;
                        if (turn_q) pos_o_d = cursor_q;
                        else        pos_x_d = cursor_q;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else begin
                    // Exactly one direction edge moves the cursor; none or several do nothing.
                    case (btn_rise_c[3:0])
                        4'b0001: cursor_d = cursor_step(cursor_q, DIR_RIGHT);
                        4'b0010: cursor_d = cursor_step(cursor_q, DIR_LEFT);
                        4'b0100: cursor_d = cursor_step(cursor_q, DIR_DOWN);
                        4'b1000: cursor_d = cursor_step(cursor_q, DIR_UP);
                        default: cursor_d = cursor_q;
                    endcase
                end
            end
            ISSUE: begin
                if (issue_cnt_q == PLAY_CW'(PLAY_CYCLES - 1)) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (game_end_c) begin
                    state_d = OVER;
                end else if (acked_c) begin
                    turn_d  = ~turn_q;
                    state_d = IDLE;
                end else if (ack_cnt_q == ACK_CW'(ACK_TIMEOUT - 1)) begin
                    reject_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            OVER: state_d = OVER;
            default: state_d = IDLE;
        endcase
        play_x_d    = (state_d == ISSUE) && !turn_q;
        play_o_d    = (state_d == ISSUE) &&  turn_q;
        game_over_d = (state_d == OVER) || game_end_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cursor_q    <= CENTER_CELL;
            turn_q      <= FIRST_PLAYER;
            pos_x_q     <= '0;
            pos_o_q     <= '0;
            play_x_q    <= 1'b0;
            play_o_q    <= 1'b0;
            reject_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            turn_q      <= turn_d;
            pos_x_q     <= pos_x_d;
            pos_o_q     <= pos_o_d;
            play_x_q    <= play_x_d;
            play_o_q    <= play_o_d;
            reject_q    <= reject_d;
            game_over_q <= game_over_d;
        end
    end

    // Saturating per-state counters, cleared whenever the state changes.
    always_ff @(posedge clk) begin
        if (rst || (state_d != state_q)) begin
            issue_cnt_q <= '0;
            ack_cnt_q   <= '0;
        end else begin
            if (state_q == ISSUE && issue_cnt_q != PLAY_CW'(PLAY_CYCLES))
                issue_cnt_q <= issue_cnt_q + PLAY_CW'(1);
            if (state_q == WAIT_ACK && ack_cnt_q != ACK_CW'(ACK_TIMEOUT))
                ack_cnt_q <= ack_cnt_q + ACK_CW'(1);
        end
    end

    assign bus.playX            = play_x_q;
    assign bus.playO            = play_o_q;
    assign bus.playerX_position = pos_x_q;
    assign bus.playerO_position = pos_o_q;
    assign bus.cursor           = cursor_q;
    assign bus.turn             = turn_q;
    assign bus.reject           = reject_q;
    assign bus.game_over        = game_over_q;
endmodule

// File: tb/tb_ttt_move_controller.sv
// Directed bench for ttt_move_controller; the bench plays the game side,
// writing board marks and the result code by hand.
module tb_ttt_move_controller;
    localparam logic [4:0] B_R = 5'b00001;
    localparam logic [4:0] B_L = 5'b00010;
    localparam logic [4:0] B_D = 5'b00100;
    localparam logic [4:0] B_U = 5'b01000;
    localparam logic [4:0] B_C = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] board [9];
    int         n_checks = 0;
    int         n_fail   = 0;

    ttt_move_if bus ();

    ttt_move_controller #(.PLAY_CYCLES(5), .ACK_TIMEOUT(16), .FIRST_PLAYER(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.pos1 = board[0];
    assign bus.pos2 = board[1];
    assign bus.pos3 = board[2];
    assign bus.pos4 = board[3];
    assign bus.pos5 = board[4];
    assign bus.pos6 = board[5];
    assign bus.pos7 = board[6];
    assign bus.pos8 = board[7];
    assign bus.pos9 = board[8];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Drive buttons high for one clock; returns at the negedge after the sampling edge.
    task automatic press(input logic [4:0] b);
        {bus.btn_confirm, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = b;
        @(negedge clk);
        {bus.btn_confirm, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = 5'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(10);
        n_checks++;
        if ({bus.playX, bus.playO, bus.reject, bus.game_over} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 0000", {bus.playX, bus.playO, bus.reject, bus.game_over});
        end
        rst = 1'b0;
        tick(1);
        n_checks++;
        if (bus.cursor !== 4'd4 || bus.turn !== 1'b1) begin
            n_fail++; $display("FAIL reset_cursor_turn: got cursor=%0d turn=%0b want cursor=4 turn=1", bus.cursor, bus.turn);
        end
        n_checks++;
        if (bus.playerX_position !== 4'd0 || bus.playerO_position !== 4'd0) begin
            n_fail++; $display("FAIL reset_positions: got X=%0d O=%0d want 0 0", bus.playerX_position, bus.playerO_position);
        end
    endtask

    task automatic test_first_move;
        press(B_C);
        for (int i = 1; i <= 5; i++) begin
            n_checks++;
            if (bus.playO !== 1'b1 || bus.playX !== 1'b0 || bus.playerO_position !== 4'd4) begin
                n_fail++; $display("FAIL first_move_strobe[%0d]: got O=%0b X=%0b posO=%0d want 1 0 4", i, bus.playO, bus.playX, bus.playerO_position);
            end
            if (i == 3) board[4] = 2'b10;
            if (i < 5) tick(1);
        end
        tick(1);
        n_checks++;
        if (bus.playO !== 1'b0 || bus.turn !== 1'b1) begin
            n_fail++; $display("FAIL first_move_end: got playO=%0b turn=%0b want 0 1", bus.playO, bus.turn);
        end
        tick(1);
        n_checks++;
        if (bus.turn !== 1'b0 || bus.playerO_position !== 4'd4) begin
            n_fail++; $display("FAIL first_move_ack: got turn=%0b posO=%0d want 0 4", bus.turn, bus.playerO_position);
        end
    endtask

    task automatic test_cursor;
        logic [4:0] seq_b [9];
        logic [3:0] seq_e [9];
        seq_b = '{B_R, B_R, B_U, B_R, B_U, B_L, B_D, B_L, B_R | B_U};
        seq_e = '{4'd5, 4'd3, 4'd0, 4'd1, 4'd7, 4'd6, 4'd0, 4'd2, 4'd2};
        for (int i = 0; i < 9; i++) begin
            press(seq_b[i]);
            n_checks++;
            if (bus.cursor !== seq_e[i]) begin
                n_fail++; $display("FAIL cursor_step[%0d]: got %0d want %0d", i, bus.cursor, seq_e[i]);
            end
            tick(1);
        end
        bus.btn_right = 1'b1;
        tick(3);
        bus.btn_right = 1'b0;
        n_checks++;
        if (bus.cursor !== 4'd0) begin
            n_fail++; $display("FAIL cursor_held: got %0d want 0", bus.cursor);
        end
        tick(1);
        press(B_D); tick(1);
        press(B_R);
        n_checks++;
        if (bus.cursor !== 4'd4) begin
            n_fail++; $display("FAIL cursor_return: got %0d want 4", bus.cursor);
        end
        tick(1);
    endtask

    task automatic test_reject;
        press(B_C | B_R);
        n_checks++;
        if (bus.reject !== 1'b1 || bus.cursor !== 4'd4 || bus.playX !== 1'b0) begin
            n_fail++; $display("FAIL reject_pulse: got rej=%0b cur=%0d playX=%0b want 1 4 0", bus.reject, bus.cursor, bus.playX);
        end
        tick(1);
        n_checks++;
        if (bus.reject !== 1'b0 || bus.playX !== 1'b0 || bus.turn !== 1'b0) begin
            n_fail++; $display("FAIL reject_after: got rej=%0b playX=%0b turn=%0b want 0 0 0", bus.reject, bus.playX, bus.turn);
        end
    endtask

    task automatic test_timeout;
        press(B_U); tick(1);
        press(B_L); tick(1);
        press(B_C);
        n_checks++;
        if (bus.playX !== 1'b1 || bus.playerX_position !== 4'd0 || bus.playerO_position !== 4'd4 || bus.playO !== 1'b0) begin
            n_fail++; $display("FAIL timeout_issue: got X=%0b posX=%0d posO=%0d O=%0b want 1 0 4 0", bus.playX, bus.playerX_position, bus.playerO_position, bus.playO);
        end
        tick(5);
        n_checks++;
        if (bus.playX !== 1'b0) begin
            n_fail++; $display("FAIL timeout_strobe_len: got playX=%0b want 0", bus.playX);
        end
        tick(15);
        n_checks++;
        if (bus.reject !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early: got reject=%0b want 0", bus.reject);
        end
        tick(1);
        n_checks++;
        if (bus.reject !== 1'b1) begin
            n_fail++; $display("FAIL timeout_reject: got reject=%0b want 1", bus.reject);
        end
        tick(1);
        n_checks++;
        if (bus.reject !== 1'b0 || bus.turn !== 1'b0) begin
            n_fail++; $display("FAIL timeout_after: got rej=%0b turn=%0b want 0 0", bus.reject, bus.turn);
        end
    endtask

    task automatic test_game_over;
        press(B_C);
        tick(5);
        bus.who = 2'b01;
        tick(1);
        n_checks++;
        if (bus.game_over !== 1'b1 || bus.playX !== 1'b0 || bus.turn !== 1'b0) begin
            n_fail++; $display("FAIL over_enter: got go=%0b playX=%0b turn=%0b want 1 0 0", bus.game_over, bus.playX, bus.turn);
        end
        press(B_C | B_R);
        tick(1);
        n_checks++;
        if (bus.cursor !== 4'd0 || bus.playX !== 1'b0 || bus.reject !== 1'b0 || bus.game_over !== 1'b1) begin
            n_fail++; $display("FAIL over_ignore: got cur=%0d playX=%0b rej=%0b go=%0b want 0 0 0 1", bus.cursor, bus.playX, bus.reject, bus.game_over);
        end
        rst = 1'b1;
        bus.who = 2'b00;
        tick(2);
        rst = 1'b0;
        tick(1);
        n_checks++;
        if (bus.cursor !== 4'd4 || bus.turn !== 1'b1 || bus.game_over !== 1'b0 || bus.playerO_position !== 4'd0) begin
            n_fail++; $display("FAIL over_reset: got cur=%0d turn=%0b go=%0b posO=%0d want 4 1 0 0", bus.cursor, bus.turn, bus.game_over, bus.playerO_position);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 9; i++) board[i] = 2'b00;
        press(B_C);
        tick(1);
        rst = 1'b1;
        tick(1);
        n_checks++;
        if (bus.playO !== 1'b0 || bus.playerO_position !== 4'd0) begin
            n_fail++; $display("FAIL mid_issue_reset: got playO=%0b posO=%0d want 0 0", bus.playO, bus.playerO_position);
        end
        rst = 1'b0;
        tick(1);
        press(B_C);
        n_checks++;
        if (bus.playO !== 1'b1 || bus.playerO_position !== 4'd4) begin
            n_fail++; $display("FAIL restart_issue: got playO=%0b posO=%0d want 1 4", bus.playO, bus.playerO_position);
        end
        board[4] = 2'b10;
        tick(5);
        n_checks++;
        if (bus.turn !== 1'b1) begin
            n_fail++; $display("FAIL b2b_turn_early: got turn=%0b want 1", bus.turn);
        end
        tick(1);
        n_checks++;
        if (bus.turn !== 1'b0) begin
            n_fail++; $display("FAIL b2b_turn: got turn=%0b want 0", bus.turn);
        end
        press(B_C);
        n_checks++;
        if (bus.reject !== 1'b1 || bus.playX !== 1'b0) begin
            n_fail++; $display("FAIL b2b_reject: got rej=%0b playX=%0b want 1 0", bus.reject, bus.playX);
        end
        tick(1);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) board[i] = 2'b00;
        bus.who = 2'b00;
        {bus.btn_confirm, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = 5'b0;
        test_reset();
        test_first_move();
        test_cursor();
        test_reject();
        test_timeout();
        test_game_over();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
